dpm_ccflags: RTL
================

// Module: dpm_ccflags
// PURPOSE
//   Condition-code stage directly downstream of the ALU datapath. Selects the ALU
//   carry, overflow, sign and zero results by data size. Registers them as micro-CC
//   (for microbranch) and as PSL N/Z/V/C under microcode control.
//   Returns the PSL C bit to the ALU as pslc_h. Sequences quad (double-cycle) Z.
// PARAMETERS
//   RESET_CC   4'b0000  reset value of psl_cc_h and ucc_h, ordered {N,Z,V,C}
//   DBL_EN     1        1 = quad two-cycle Z accumulation; 0 = FSM tied to IDLE
// PORTS
//   qd_clk_l        in   1  datapath clock; all state updates on its rising edge
//   reset_l         in   1  asynchronous, active-low reset
//   ccctl_h         in   3  microcode CC control (encodings below)
//   dsize_h         in   2  00 byte, 01 word, 10 long, 11 quad
//   double_enable_h in   1  ALU double-cycle in progress (quad ops)
//   alu_c31_l/c15_l/c7_l in 1 each  ALU carry outs, active low
//   alu_v31_h/v15_h/v7_h in 1 each  ALU overflow outs
//   wmuxz_h         in   4  per-byte zero of write bus, [0]=bits 7:0
//   wbus_h          in  32  write bus (sign bits 31/15/7; bits 3:0 for CC load)
//   psl_cc_h        out  4  registered PSL {N,Z,V,C}
//   ucc_h           out  4  registered micro-CC {N,Z,V,C}
//   pslc_h          out  1  = psl_cc_h[0], ALU carry-in source
//   dbl_busy_h      out  1  FSM in SECOND state
// BEHAVIOUR
//   - Reset (async): psl_cc_h = ucc_h = RESET_CC; z_lo = 0; FSM = IDLE;
//     dbl_busy_h = 0. Reset mid-quad discards the captured low half.
//   - Size select (combinational), C taken as active-high ~c_l:
//     byte  N=wbus[7],  Z=wmuxz[0],    V=v7,  C=~c7_l
//     word  N=wbus[15], Z=&wmuxz[1:0], V=v15, C=~c15_l
//     long/quad  N=wbus[31], Z=&wmuxz, V=v31, C=~c31_l
//   - ccctl_h (one-cycle latency: registers hold new value after the edge):
//     000 HOLD  no change
//     001 UCC   ucc <= sel; PSL held
//     010 ARITH ucc <= sel; psl <= sel
//     011 SUBB  ucc <= sel; psl <= {N,Z,V,~C} (VAX borrow)
//     100 MOVE  psl <= {N,Z,0,psl.C}; ucc <= sel
//     101 LOGIC psl <= {N,Z,0,0}; ucc <= sel
//     110 WRCC  psl <= wbus_h[3:0]; ucc held
//     111 CLR   psl <= 4'b0000; ucc held
//   - Quad FSM (DBL_EN=1), states IDLE, SECOND:
//     IDLE->SECOND: double_enable_h=1 and ccctl in {001..101}. Capture
//       z_lo <= &wmuxz. No CC register updates this cycle.
//     SECOND->IDLE: next cycle with ccctl in {001..101}. Update as above,
//       except Z = z_lo & &wmuxz. N/V/C come from the high longword.
//     SECOND with ccctl=000: hold SECOND (stall); z_lo retained.
//     SECOND with ccctl=110/111: apply WRCC/CLR, abort to IDLE, drop z_lo.
//     double_enable_h with ccctl 000/110/111 in IDLE: no FSM transition.
//   - dsize_h is ignored for Z in SECOND (always full 32-bit).
//   - pslc_h follows the psl_cc_h[0] register with no combinational path from inputs.
//   - X/Z on unused inputs must not affect state when ccctl=000.
// STRUCTURE
//   - Shared package dpm_pkg: CC_HOLD..CC_CLR encodings (3 bits), DSIZE_BYTE/WORD/
//     LONG/QUAD, CC bit indices CC_N=3, CC_Z=2, CC_V=1, CC_C=0, FSM state enum.
//   - Sub-module dpm_ccsel: the combinational size-select mux. Outputs sel {N,Z,V,C}
//     and z32.
//   - Top holds the psl/ucc registers, z_lo, and the 2-state FSM.
// TESTING
//   1. Reset: reset_l=0 mid-SECOND -> psl_cc_h=0000, ucc_h=0000, dbl_busy_h=0 asynchronously.
//   2. Byte ARITH: dsize=00, wbus=32'h80, wmuxz=4'b1110, c7_l=0, v7=1, ccctl=010
//      -> next cycle psl_cc_h=1011, pslc_h=1.
//   3. SUBB long: dsize=10, wbus=0, wmuxz=1111, c31_l=1, ccctl=011 -> psl_cc_h=0101.
//   4. MOVE keeps C: psl C=1; MOVE with wbus[15]=1, dsize=01 -> psl_cc_h=1001.
//   5. Quad, low half nonzero: cycle1 dbl=1, ARITH, wmuxz=0111 -> dbl_busy_h=1, psl held.
//      Cycle2 wmuxz=1111 -> psl Z=0. Repeat with low half zero -> Z=1.
//   6. Abort: in SECOND apply ccctl=110, wbus[3:0]=4'hA -> psl_cc_h=1010, FSM IDLE.
//      Next quad uses fresh z_lo.

Source files
------------

// File: rtl/dpm_pkg.sv
// ---------------------------------------------------------------------------
// dpm_pkg
//   Shared definitions for the condition-code stage that sits behind the ALU
//   datapath: microcode CC control encodings, data-size encodings, the bit
//   positions of N/Z/V/C inside a 4-bit CC vector, and the quad sequencer
//   state type.
// ---------------------------------------------------------------------------
package dpm_pkg;

    // Microcode CC control field
    localparam logic [2:0] CC_HOLD  = 3'b000;
    localparam logic [2:0] CC_UCC   = 3'b001;
    localparam logic [2:0] CC_ARITH = 3'b010;
    localparam logic [2:0] CC_SUBB  = 3'b011;
    localparam logic [2:0] CC_MOVE  = 3'b100;
    localparam logic [2:0] CC_LOGIC = 3'b101;
    localparam logic [2:0] CC_WRCC  = 3'b110;
    localparam logic [2:0] CC_CLR   = 3'b111;

    // Operand data size
    localparam logic [1:0] DSIZE_BYTE = 2'b00;
    localparam logic [1:0] DSIZE_WORD = 2'b01;
    localparam logic [1:0] DSIZE_LONG = 2'b10;
    localparam logic [1:0] DSIZE_QUAD = 2'b11;

    // Bit positions within a {N,Z,V,C} vector
    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_V = 1;
    localparam int CC_C = 0;

    // Quad (double-cycle) Z sequencer
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } dbl_state_t;

    // True for the control codes that take their CC values from the ALU
    // result (UCC through LOGIC); these are the ones that can start or
    // finish a quad operation.
    function automatic logic cc_is_update(input logic [2:0] ccctl);
        return (ccctl >= CC_UCC) && (ccctl <= CC_LOGIC);
    endfunction

endpackage

// File: rtl/dpm_ccsel.sv
// ---------------------------------------------------------------------------
// dpm_ccsel
//   Combinational size-select mux. Picks the carry, overflow, sign and zero
//   result that matches the operand size. Carries arrive active low from the
//   ALU and are inverted here so sel_cc carries an active-high C.
// Ports
//   dsize_h      in   2  operand size (byte/word/long/quad)
//   alu_c*_l     in   1  ALU carry outs at bits 31/15/7, active low
//   alu_v*_h     in   1  ALU overflow outs at bits 31/15/7
//   wmuxz_h      in   4  per-byte zero flags of the write bus
//   wbus_h       in  32  write bus (sign bits only are used here)
//   sel_cc       out  4  size-selected {N,Z,V,C}
//   z32          out  1  full 32-bit zero, independent of size
// ---------------------------------------------------------------------------
module dpm_ccsel
    import dpm_pkg::*;
(
    input  logic [1:0]  dsize_h,
    input  logic        alu_c31_l,
    input  logic        alu_c15_l,
    input  logic        alu_c7_l,
    input  logic        alu_v31_h,
    input  logic        alu_v15_h,
    input  logic        alu_v7_h,
    input  logic [3:0]  wmuxz_h,
    input  logic [31:0] wbus_h,
    output logic [3:0]  sel_cc,
    output logic        z32
);

    // Only the three sign positions of the write bus matter to this mux.
    logic unused_wbus;
    assign unused_wbus = ^{wbus_h[30:16], wbus_h[14:8], wbus_h[6:0]};

    assign z32 = &wmuxz_h;

    // Long and quad share the 32-bit selection; for quad the ALU is working
    // on the high longword when these results are consumed.
    always_comb begin
        sel_cc = '0;
        case (dsize_h)
            DSIZE_BYTE: begin
                sel_cc[CC_N] = wbus_h[7];
                sel_cc[CC_Z] = wmuxz_h[0];
                sel_cc[CC_V] = alu_v7_h;
                sel_cc[CC_C] = ~alu_c7_l;
            end
            DSIZE_WORD: begin
                sel_cc[CC_N] = wbus_h[15];
                sel_cc[CC_Z] = &wmuxz_h[1:0];
                sel_cc[CC_V] = alu_v15_h;
                sel_cc[CC_C] = ~alu_c15_l;
            end
            default: begin
                sel_cc[CC_N] = wbus_h[31];
                sel_cc[CC_Z] = z32;
                sel_cc[CC_V] = alu_v31_h;
                sel_cc[CC_C] = ~alu_c31_l;
            end
        endcase
    end

endmodule

// File: rtl/dpm_ccflags.sv
// ---------------------------------------------------------------------------
// dpm_ccflags
//   Condition-code stage behind the ALU. Registers the size-selected CC
//   results as micro-CC (for microbranch) and as PSL N/Z/V/C under microcode
//   control, feeds PSL C back to the ALU, and sequences two-cycle quad Z.
// Parameters
//   RESET_CC   reset value of psl_cc_h and ucc_h, {N,Z,V,C}
//   DBL_EN     1 enables the quad Z sequencer; 0 keeps it in IDLE
// Ports
//   qd_clk_l         in   1  datapath clock, state changes on rising edge
//   reset_l          in   1  asynchronous active-low reset
//   ccctl_h          in   3  microcode CC control
//   dsize_h          in   2  operand size
//   double_enable_h  in   1  ALU double-cycle (quad) in progress
//   alu_c*_l         in   1  ALU carry outs, active low
//   alu_v*_h         in   1  ALU overflow outs
//   wmuxz_h          in   4  per-byte zero of the write bus
//   wbus_h           in  32  write bus
//   psl_cc_h         out  4  PSL {N,Z,V,C}
//   ucc_h            out  4  micro-CC {N,Z,V,C}
//   pslc_h           out  1  PSL C, ALU carry-in source
//   dbl_busy_h       out  1  sequencer waiting for the high longword
// ---------------------------------------------------------------------------
module dpm_ccflags
    import dpm_pkg::*;
#(
    parameter logic [3:0] RESET_CC = 4'b0000,
    parameter bit         DBL_EN   = 1'b1
) (
    input  logic        qd_clk_l,
    input  logic        reset_l,
    input  logic [2:0]  ccctl_h,
    input  logic [1:0]  dsize_h,
    input  logic        double_enable_h,
    input  logic        alu_c31_l,
    input  logic        alu_c15_l,
    input  logic        alu_c7_l,
    input  logic        alu_v31_h,
    input  logic        alu_v15_h,
    input  logic        alu_v7_h,
    input  logic [3:0]  wmuxz_h,
    input  logic [31:0] wbus_h,
    output logic [3:0]  psl_cc_h,
    output logic [3:0]  ucc_h,
    output logic        pslc_h,
    output logic        dbl_busy_h
);

    logic [3:0] sel_cc;
    logic       z32;
    logic [3:0] cc_eff;

    logic [3:0] psl_q, psl_d;
    logic [3:0] ucc_q, ucc_d;
    logic       z_lo_q, z_lo_d;
    logic       apply_en;
    dbl_state_t state_q, state_d;

    dpm_ccsel u_ccsel (
        .dsize_h   (dsize_h),
        .alu_c31_l (alu_c31_l),
        .alu_c15_l (alu_c15_l),
        .alu_c7_l  (alu_c7_l),
        .alu_v31_h (alu_v31_h),
        .alu_v15_h (alu_v15_h),
        .alu_v7_h  (alu_v7_h),
        .wmuxz_h   (wmuxz_h),
        .wbus_h    (wbus_h),
        .sel_cc    (sel_cc),
        .z32       (z32)
    );

    // Next-state logic. The first half of a quad only captures the low
    // longword zero; the second half applies the CC update with Z combined
    // across both longwords. HOLD in SECOND stalls with z_lo kept; WRCC/CLR
    // in SECOND still take effect but abandon the quad.
    always_comb begin
        state_d  = state_q;
        psl_d    = psl_q;
        ucc_d    = ucc_q;
        z_lo_d   = z_lo_q;
        apply_en = 1'b0;
        cc_eff   = sel_cc;

        if (state_q == ST_SECOND) begin
            cc_eff[CC_Z] = z_lo_q & z32;
        end

        if (state_q == ST_IDLE) begin
            if (DBL_EN && cc_is_update(ccctl_h) && double_enable_h) begin
                state_d = ST_SECOND;
                z_lo_d  = z32;
            end else begin
                apply_en = 1'b1;
            end
        end else begin
            if (ccctl_h != CC_HOLD) begin
                apply_en = 1'b1;
                state_d  = ST_IDLE;
                z_lo_d   = 1'b0;
            end
        end

        // HOLD touches nothing, so undriven ALU inputs cannot leak in.
        if (apply_en) begin
            case (ccctl_h)
                CC_UCC: begin
                    ucc_d = cc_eff;
                end
                CC_ARITH: begin
                    ucc_d = cc_eff;
                    psl_d = cc_eff;
                end
                CC_SUBB: begin
                    ucc_d = cc_eff;
                    psl_d = {cc_eff[CC_N], cc_eff[CC_Z], cc_eff[CC_V], ~cc_eff[CC_C]};
                end
                CC_MOVE: begin
                    ucc_d = cc_eff;
                    psl_d = {cc_eff[CC_N], cc_eff[CC_Z], 1'b0, psl_q[CC_C]};
                end
                CC_LOGIC: begin
                    ucc_d = cc_eff;
                    psl_d = {cc_eff[CC_N], cc_eff[CC_Z], 2'b00};
                end
                CC_WRCC: begin
                    psl_d = wbus_h[3:0];
                end
                CC_CLR: begin
                    psl_d = 4'b0000;
                end
                default: begin
                    psl_d = psl_q;
                end
            endcase
        end
    end

    // State registers. Reset drops any half-finished quad.
    always_ff @(posedge qd_clk_l or negedge reset_l) begin
        if (!reset_l) begin
            psl_q   <= RESET_CC;
            ucc_q   <= RESET_CC;
            z_lo_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            psl_q   <= psl_d;
            ucc_q   <= ucc_d;
            z_lo_q  <= z_lo_d;
            state_q <= state_d;
        end
    end

    assign psl_cc_h   = psl_q;
    assign ucc_h      = ucc_q;
    assign pslc_h     = psl_q[CC_C];
    assign dbl_busy_h = (state_q == ST_SECOND);

endmodule
